io_out_port: RTL and testbench
==============================

Name: io_out_port

Overview:
- CPU-side output port; the transmit counterpart of the register-file input port slot.
- Core writes bytes with a single-cycle write enable. Writes are buffered in a small FIFO.
- Bytes are drained to an external device over a four-phase STB/ACK handshake.
- Sits beside the register file on the core data bus; exposes FIFO and error status for polling.

Parameters:
- WIDTH, 8, data width of bus and port.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- TIMEOUT_CYC, 255, cycles STB may stay high without ACK (used only with the optional feature).

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  reset; asynchronous, active-low.
- IN  input  WIDTH  write data from core.
- WE  input  1  write enable, sampled at CLK rising edge.
- CLR  input  1  synchronous clear of sticky flags OVF and TOERR.
- PORT_DATA  output  WIDTH  data presented to external device (registered).
- PORT_STB  output  1  strobe; data valid while high (registered).
- PORT_ACK  input  1  external acknowledge; treated as already synchronous to CLK.
- FULL  output  1  FIFO full.
- EMPTY  output  1  FIFO empty.
- BUSY  output  1  handshake FSM not in IDLE.
- OVF  output  1  sticky; a write was dropped.
- TOERR  output  1  sticky; handshake timeout.

Behaviour:
- Reset (RST_N low, asynchronous): FIFO pointers and count = 0; PORT_DATA = 0; PORT_STB = 0; FSM = IDLE. Resulting outputs: EMPTY = 1, FULL = 0, BUSY = 0, OVF = 0, TOERR = 0.
- Reset mid-handshake: STB drops immediately and the in-flight byte is lost. FIFO contents are lost.
- FIFO write:
  - WE with count < DEPTH: store IN at the write pointer, increment it.
  - WE with count == DEPTH: drop the byte and set OVF.
  - Exception: if a pop occurs in the same cycle, the write is accepted, count is unchanged and OVF is not set.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1. FULL = (count == DEPTH); EMPTY = (count == 0).
- FSM states: IDLE, REQ, REL.
  - IDLE: if !EMPTY and !PORT_ACK, then PORT_DATA <= FIFO head, pop, PORT_STB <= 1, go to REQ. Otherwise hold.
  - REQ: if PORT_ACK, then PORT_STB <= 0, go to REL. PORT_DATA is held stable throughout REQ.
  - REL: if !PORT_ACK, go to IDLE. Otherwise hold.
- Latency: a byte written at edge t into an empty FIFO with the FSM in IDLE and ACK low gives PORT_STB = 1 after edge t+1.
- Minimum per-byte cycle is 3 clocks when the device responds immediately.
- Simultaneous WE and CLR: both take effect. If that same WE overflows, OVF = 1 (set wins over clear); same rule for TOERR.
- ACK high while in IDLE holds the FSM in IDLE; no new STB is raised.
- Core writes never stall; the only flow-control signals the core needs are FULL and OVF.

Optional Feature:
- Macro: OUT_PORT_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments every cycle in REQ.
  - When it reaches TIMEOUT_CYC with ACK still low: PORT_STB <= 0, TOERR <= 1, FSM -> IDLE. The byte is discarded and the FIFO continues draining.
- Not defined: REQ waits indefinitely, no counter is synthesised, TOERR is tied 0.

Decomposition:
- Shared package io_pkg holds:
  - FSM state encodings ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_REL = 2'd2.
  - Default WIDTH/DEPTH constants, reused by the input-port logic.
- One sub-module: sync_fifo (WIDTH, DEPTH; push/pop, full/empty/count).
- io_out_port contains the FSM, the output registers, the sticky flags and the optional timeout counter.

Test Plan:
- Reset then write 0xA5 at edge 1, ACK tied to delayed STB (1 cycle) -> PORT_STB rises after edge 2 with PORT_DATA=0xA5; STB falls 1 cycle after ACK; BUSY=0 after ACK falls; EMPTY=1.
- Hold ACK low, write 0x01,0x02,0x03,0x04,0x05 on consecutive cycles (DEPTH=4):
  - Expected: first byte pops into REQ, the next 4 fill the FIFO, FULL=1, OVF=0.
  - Sixth write 0x06 -> dropped, OVF=1.
  - Releasing ACK handshakes then drains 0x01..0x05 in order.
- Write while FULL on the same cycle the FSM pops -> write accepted, count stays DEPTH, OVF stays 0, byte appears later in order.
- Assert RST_N low mid-REQ with 3 bytes queued -> PORT_STB=0, EMPTY=1, BUSY=0 immediately, before the next edge.
- With OUT_PORT_TIMEOUT_EN, TIMEOUT_CYC=10, ACK never rises:
  - Expected: STB high for exactly 10 cycles, then low, TOERR=1, next byte is presented.
  - Pulse CLR -> TOERR=0.
- Without the macro, same stimulus -> STB stays high for 1000 cycles, TOERR=0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared I/O port package: FSM encodings and default sizes.
package io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_e;

  localparam int IO_WIDTH = 8;
  localparam int IO_DEPTH = 4;

endpackage

// File: rtl/io_out_port_if.sv
// Four-phase STB/ACK device handshake bundle.
interface io_out_port_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] PORT_DATA;
  logic             PORT_STB;
  logic             PORT_ACK;

  modport master (
    output PORT_DATA,
    output PORT_STB,
    input  PORT_ACK
  );

  modport slave (
    input  PORT_DATA,
    input  PORT_STB,
    output PORT_ACK
  );

endinterface

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO, show-ahead head, push allowed on full+pop.
module sync_fifo
  import io_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/io_out_port.sv
// CPU output port: write FIFO drained over a four-phase STB/ACK handshake.
// Optional REQ timeout enabled by OUT_PORT_TIMEOUT_EN.
module io_out_port
  import io_pkg::*;
#(
  parameter int WIDTH       = IO_WIDTH,
  parameter int DEPTH       = IO_DEPTH,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] IN,
  input  logic             WE,
  input  logic             CLR,
  io_out_port_if.master    port,
  output logic             FULL,
  output logic             EMPTY,
  output logic             BUSY,
  output logic             OVF,
  output logic             TOERR
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e           state;
  state_e           nstate;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] data_q;
  logic             stb_q;
  logic             stb_d;
  logic             pop;
  logic             ack;
  logic             tmo;
  logic             ovf_q;
  logic             ovf_set;

  assign ack = port.PORT_ACK;
  assign port.PORT_DATA = data_q;
  assign port.PORT_STB  = stb_q;
  assign BUSY = (state != ST_IDLE);
  assign OVF  = ovf_q;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (WE),
    .pop   (pop),
    .din   (IN),
    .dout  (head),
    .full  (FULL),
    .empty (EMPTY),
    .count (cnt)
  );

  // A pop in the same cycle makes room, so only a stalled full write drops.
  assign ovf_set = WE && (cnt == CW'(DEPTH)) && !pop;

`ifdef OUT_PORT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tcnt;
  logic          toerr_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                tcnt <= '0;
    else if (state != ST_REQ) tcnt <= '0;
    else                      tcnt <= tcnt + TW'(1);
  end

  // tcnt reaches TIMEOUT_CYC on this edge: STB was high TIMEOUT_CYC cycles.
  assign tmo = (state == ST_REQ) && !ack
            && (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)   toerr_q <= 1'b0;
    else if (tmo) toerr_q <= 1'b1;
    else if (CLR) toerr_q <= 1'b0;
  end

  assign TOERR = toerr_q;
`else
  logic [31:0] unused_tmo_cyc;

  assign unused_tmo_cyc = TIMEOUT_CYC;
  assign tmo   = 1'b0;
  assign TOERR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      ST_IDLE: if (pop) nstate = ST_REQ;
      ST_REQ: begin
        if (ack)      nstate = ST_REL;
        else if (tmo) nstate = ST_IDLE;
      end
      ST_REL:  if (!ack) nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  always_comb begin
    pop   = 1'b0;
    stb_d = stb_q;
    unique case (1'b1)
      (state == ST_IDLE): begin
        pop = !EMPTY && !ack;
        if (pop) stb_d = 1'b1;
      end
      (state == ST_REQ): begin
        if (ack || tmo) stb_d = 1'b0;
      end
      default: stb_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_q <= '0;
      stb_q  <= 1'b0;
    end else begin
      stb_q <= stb_d;
      if (pop) data_q <= head;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
    else if (CLR)     ovf_q <= 1'b0;
  end

endmodule

// File: tb/tb_io_out_port.sv
// Directed self-checking bench for io_out_port.
module tb_io_out_port;

`ifdef OUT_PORT_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 255;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] IN;
  logic       WE;
  logic       CLR;
  logic       FULL, EMPTY, BUSY, OVF, TOERR;
  logic       auto_ack;
  logic       ack_man;
  logic       ack_d;
  int         checks = 0;
  int         errors = 0;
  int         stb_low;

  io_out_port_if #(.WIDTH(8)) pif ();

  io_out_port #(
    .WIDTH       (8),
    .DEPTH       (4),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .IN    (IN),
    .WE    (WE),
    .CLR   (CLR),
    .port  (pif),
    .FULL  (FULL),
    .EMPTY (EMPTY),
    .BUSY  (BUSY),
    .OVF   (OVF),
    .TOERR (TOERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge RST_N)
    if (!RST_N) ack_d <= 1'b0;
    else        ack_d <= pif.PORT_STB;

  assign pif.PORT_ACK = auto_ack ? ack_d : ack_man;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic handshake(input logic [7:0] exp);
    check("hs_stb_hi", 32'(pif.PORT_STB), 1);
    check("hs_data", 32'(pif.PORT_DATA), 32'(exp));
    ack_man = 1'b1;
    tick();
    check("hs_stb_lo", 32'(pif.PORT_STB), 0);
    ack_man = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; IN = '0; WE = 1'b0; CLR = 1'b0;
    auto_ack = 1'b1; ack_man = 1'b0;
    #12;
    check("rst_empty", 32'(EMPTY), 1);
    check("rst_full", 32'(FULL), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_ovf", 32'(OVF), 0);
    check("rst_toerr", 32'(TOERR), 0);
    check("rst_stb", 32'(pif.PORT_STB), 0);
    check("rst_data", 32'(pif.PORT_DATA), 0);
    RST_N = 1'b1;

    // single byte, device acks one cycle after STB
    IN = 8'hA5; WE = 1'b1;
    tick();
    WE = 1'b0;
    check("t1_stb_e1", 32'(pif.PORT_STB), 0);
    check("t1_empty_e1", 32'(EMPTY), 0);
    tick();
    check("t1_stb_e2", 32'(pif.PORT_STB), 1);
    check("t1_data_e2", 32'(pif.PORT_DATA), 32'h A5);
    check("t1_busy_e2", 32'(BUSY), 1);
    tick();
    check("t1_ack_e3", 32'(pif.PORT_ACK), 1);
    check("t1_stb_e3", 32'(pif.PORT_STB), 1);
    tick();
    check("t1_stb_e4", 32'(pif.PORT_STB), 0);
    check("t1_busy_e4", 32'(BUSY), 1);
    tick();
    check("t1_ack_e5", 32'(pif.PORT_ACK), 0);
    tick();
    check("t1_busy_e6", 32'(BUSY), 0);
    check("t1_empty_e6", 32'(EMPTY), 1);
    auto_ack = 1'b0;

    // fill behind a stalled handshake, then overflow
    for (int i = 1; i <= 5; i++) begin
      IN = 8'(i); WE = 1'b1;
      tick();
    end
    check("t2_full", 32'(FULL), 1);
    check("t2_ovf0", 32'(OVF), 0);
    check("t2_stb", 32'(pif.PORT_STB), 1);
    check("t2_data", 32'(pif.PORT_DATA), 1);
    IN = 8'h06;
    tick();
    WE = 1'b0;
    check("t2_ovf1", 32'(OVF), 1);
    check("t2_full2", 32'(FULL), 1);
    for (int i = 1; i <= 5; i++) handshake(8'(i));
    check("t2_stb_end", 32'(pif.PORT_STB), 0);
    check("t2_busy_end", 32'(BUSY), 0);
    check("t2_empty_end", 32'(EMPTY), 1);
    check("t2_ovf_hold", 32'(OVF), 1);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check("t2_clr", 32'(OVF), 0);

    // ACK high in IDLE blocks draining; full write on pop is accepted
    ack_man = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      IN = 8'(i * 8'h11); WE = 1'b1;
      tick();
    end
    WE = 1'b0;
    check("t3_full", 32'(FULL), 1);
    check("t3_idle", 32'(BUSY), 0);
    check("t3_nostb", 32'(pif.PORT_STB), 0);
    IN = 8'h99; WE = 1'b1; CLR = 1'b1;
    tick();
    WE = 1'b0;
    check("t3_set_wins", 32'(OVF), 1);
    tick();
    CLR = 1'b0;
    check("t3_clr", 32'(OVF), 0);
    ack_man = 1'b0;
    IN = 8'h55; WE = 1'b1;
    tick();
    WE = 1'b0;
    check("t3_full_pop", 32'(FULL), 1);
    check("t3_ovf", 32'(OVF), 0);
    for (int i = 1; i <= 5; i++) handshake(8'(i * 8'h11));
    check("t3_empty", 32'(EMPTY), 1);
    check("t3_ovf_end", 32'(OVF), 0);

    // asynchronous reset mid-REQ with three bytes queued
    for (int i = 0; i < 4; i++) begin
      IN = 8'hC0 + 8'(i); WE = 1'b1;
      tick();
    end
    WE = 1'b0;
    check("t4_stb", 32'(pif.PORT_STB), 1);
    check("t4_data", 32'(pif.PORT_DATA), 32'h C0);
    check("t4_notempty", 32'(EMPTY), 0);
    #2 RST_N = 1'b0;
    #1;
    check("t4_rst_stb", 32'(pif.PORT_STB), 0);
    check("t4_rst_empty", 32'(EMPTY), 1);
    check("t4_rst_busy", 32'(BUSY), 0);
    check("t4_rst_data", 32'(pif.PORT_DATA), 0);
    #2 RST_N = 1'b1;
    tick();

    // device never acknowledges
    IN = 8'h77; WE = 1'b1;
    tick();
    IN = 8'h88;
    tick();
    WE = 1'b0;
    check("t5_stb", 32'(pif.PORT_STB), 1);
    check("t5_data", 32'(pif.PORT_DATA), 32'h 77);
`ifdef OUT_PORT_TIMEOUT_EN
    stb_low = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (!pif.PORT_STB) stb_low++;
    end
    check("t5_stb_held", 32'(stb_low), 0);
    tick();
    check("t5_to_stb", 32'(pif.PORT_STB), 0);
    check("t5_toerr", 32'(TOERR), 1);
    check("t5_to_idle", 32'(BUSY), 0);
    tick();
    check("t5_next_stb", 32'(pif.PORT_STB), 1);
    check("t5_next_data", 32'(pif.PORT_DATA), 32'h 88);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check("t5_clr", 32'(TOERR), 0);
`else
    stb_low = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!pif.PORT_STB) stb_low++;
    end
    check("t5_stb_held", 32'(stb_low), 0);
    check("t5_toerr", 32'(TOERR), 0);
    check("t5_data_hold", 32'(pif.PORT_DATA), 32'h 77);
    check("t5_busy", 32'(BUSY), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
